fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_arbiter.sv | 157 +++++++++++++++
 tb/tb_fb_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Two-player frame-buffer arbiter: round-robin single-bit reads/writes to a
// synchronous RAM, plus a full-buffer clear sweep that takes priority.
module fb_arbiter #(
   parameter int FB_WORDS = 307200
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear_start,
   output logic        clear_busy,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [18:0] p1_addr,
   input  logic        p1_wdata,
   output logic        p1_ack,
   output logic        p1_rdata,
   input  logic        p2_req,
   input  logic        p2_we,
   input  logic [18:0] p2_addr,
   input  logic        p2_wdata,
   output logic        p2_ack,
   output logic        p2_rdata,
   output logic [18:0] ram_write_address,
   output logic        ram_write_data,
   output logic        ram_write_enabled,
   input  logic        ram_read_data
);

   localparam logic [18:0] LAST_ADDR = 19'(FB_WORDS - 1);

   typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RD_ACK, CLEAR} state_t;

   state_t      state, state_nxt;
   logic [18:0] counter, counter_nxt;
   logic        pend_clear, pend_nxt;
   logic        last_grant, last_nxt;   // 0 = player 1, 1 = player 2
   logic        cur, cur_nxt;           // player owning the current read
   logic        gnt, gnt_we, gnt_wdata;
   logic [18:0] gnt_addr, cur_addr;
   logic        rd_bit;
   logic        busy_nxt, we_nxt, data_nxt;
   logic        p1_ack_nxt, p2_ack_nxt, p1_rdata_nxt, p2_rdata_nxt;
   logic [18:0] addr_nxt;

   // On a tie the player not served last wins; a lone requester wins outright.
   assign gnt       = (p1_req && p2_req) ? ~last_grant : p2_req;
   assign gnt_we    = gnt ? p2_we    : p1_we;
   assign gnt_addr  = gnt ? p2_addr  : p1_addr;
   assign gnt_wdata = gnt ? p2_wdata : p1_wdata;
   assign cur_addr  = cur ? p2_addr  : p1_addr;
   // Off-screen pixels read as occupied.
   assign rd_bit    = (cur_addr > LAST_ADDR) ? 1'b1 : ram_read_data;

   always_comb begin
      state_nxt    = state;
      counter_nxt  = counter;
      pend_nxt     = pend_clear;
      last_nxt     = last_grant;
      cur_nxt      = cur;
      addr_nxt     = ram_write_address;
      data_nxt     = ram_write_data;
      we_nxt       = 1'b0;
      busy_nxt     = 1'b0;
      p1_ack_nxt   = 1'b0;
      p2_ack_nxt   = 1'b0;
      p1_rdata_nxt = p1_rdata;
      p2_rdata_nxt = p2_rdata;

      if (clear_start && (state == WR || state == RD_ADDR ||
                          state == RD_DATA || state == RD_ACK))
         pend_nxt = 1'b1;

      case (state)
         IDLE: begin
            if (clear_start || pend_clear) begin
               state_nxt   = CLEAR;
               counter_nxt = '0;
               pend_nxt    = 1'b0;
               busy_nxt    = 1'b1;
               we_nxt      = 1'b1;
               data_nxt    = 1'b0;
               addr_nxt    = '0;
            end else if (p1_req || p2_req) begin
               cur_nxt  = gnt;
               last_nxt = gnt;
               addr_nxt = gnt_addr;
               if (gnt_we) begin
                  state_nxt  = WR;
                  data_nxt   = gnt_wdata;
                  we_nxt     = (gnt_addr <= LAST_ADDR);
                  p1_ack_nxt = ~gnt;
                  p2_ack_nxt = gnt;
               end else begin
                  state_nxt = RD_ADDR;
               end
            end
         end
         WR:      state_nxt = IDLE;
         RD_ADDR: state_nxt = RD_DATA;
         RD_DATA: begin
            state_nxt = RD_ACK;
            if (cur) begin
               p2_ack_nxt   = 1'b1;
               p2_rdata_nxt = rd_bit;
            end else begin
               p1_ack_nxt   = 1'b1;
               p1_rdata_nxt = rd_bit;
            end
         end
         RD_ACK:  state_nxt = IDLE;
         CLEAR: begin
            if (counter == LAST_ADDR) begin
               state_nxt = IDLE;
            end else begin
               counter_nxt = counter + 19'd1;
               addr_nxt    = counter + 19'd1;
               busy_nxt    = 1'b1;
               we_nxt      = 1'b1;
               data_nxt    = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         counter           <= '0;
         pend_clear        <= 1'b0;
         last_grant        <= 1'b1;
         cur               <= 1'b0;
         clear_busy        <= 1'b0;
         p1_ack            <= 1'b0;
         p2_ack            <= 1'b0;
         p1_rdata          <= 1'b0;
         p2_rdata          <= 1'b0;
         ram_write_address <= '0;
         ram_write_data    <= 1'b0;
         ram_write_enabled <= 1'b0;
      end else begin
         state             <= state_nxt;
         counter           <= counter_nxt;
         pend_clear        <= pend_nxt;
         last_grant        <= last_nxt;
         cur               <= cur_nxt;
         clear_busy        <= busy_nxt;
         p1_ack            <= p1_ack_nxt;
         p2_ack            <= p2_ack_nxt;
         p1_rdata          <= p1_rdata_nxt;
         p2_rdata          <= p2_rdata_nxt;
         ram_write_address <= addr_nxt;
         ram_write_data    <= data_nxt;
         ram_write_enabled <= we_nxt;
      end
   end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed testbench for fb_arbiter with a small frame buffer and a
// behavioural synchronous RAM.
module tb_fb_arbiter;
   localparam int FB = 8000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        clear_start = 1'b0;
   logic        clear_busy;
   logic        p1_req = 1'b0, p1_we = 1'b0, p1_wdata = 1'b0;
   logic [18:0] p1_addr = '0;
   logic        p1_ack, p1_rdata;
   logic        p2_req = 1'b0, p2_we = 1'b0, p2_wdata = 1'b0;
   logic [18:0] p2_addr = '0;
   logic        p2_ack, p2_rdata;
   logic [18:0] ram_write_address;
   logic        ram_write_data, ram_write_enabled;
   logic        ram_read_data;

   bit          mem [0:524287];
   logic        pl_we = 1'b0;
   logic [18:0] pl_addr = '0;
   logic        pl_d = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [25:0] outs;
   assign outs = {clear_busy, p1_ack, p2_ack, p1_rdata, p2_rdata,
                  ram_write_enabled, ram_write_data, ram_write_address};

   fb_arbiter #(.FB_WORDS(FB)) dut (
      .clock(clock), .reset(reset),
      .clear_start(clear_start), .clear_busy(clear_busy),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_rdata(p1_rdata),
      .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
      .p2_ack(p2_ack), .p2_rdata(p2_rdata),
      .ram_write_address(ram_write_address), .ram_write_data(ram_write_data),
      .ram_write_enabled(ram_write_enabled), .ram_read_data(ram_read_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (pl_we) mem[pl_addr] <= pl_d;
      else if (ram_write_enabled) mem[ram_write_address] <= ram_write_data;
      ram_read_data <= mem[ram_write_address];
   end

   task automatic preload(input logic [18:0] a, input logic d);
      pl_addr = a; pl_d = d; pl_we = 1'b1;
      @(negedge clock);
      pl_we = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_checks++;
      if (outs !== 26'd0) begin
         n_fail++; $display("FAIL reset_held: outputs=%h expected 0", outs);
      end
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (outs !== 26'd0) begin
         n_fail++; $display("FAIL reset_release: outputs=%h expected 0", outs);
      end
   endtask

   task automatic test_tie();
      p1_req = 1; p1_we = 1; p1_addr = 19'h00100; p1_wdata = 1;
      p2_req = 1; p2_we = 1; p2_addr = 19'h00200; p2_wdata = 1;
      @(negedge clock);
      n_checks++;
      if ({p1_ack, p2_ack, ram_write_enabled, ram_write_data} !== 4'b1011 || ram_write_address !== 19'h00100) begin
         n_fail++; $display("FAIL tie_p1_first: ack1/ack2/we/d=%b addr=%h expected 1011 addr 00100",
                            {p1_ack, p2_ack, ram_write_enabled, ram_write_data}, ram_write_address);
      end
      p1_req = 0;
      @(negedge clock);
      n_checks++;
      if ({p1_ack, p2_ack, ram_write_enabled} !== 3'b000) begin
         n_fail++; $display("FAIL tie_gap: ack1/ack2/we=%b expected 000", {p1_ack, p2_ack, ram_write_enabled});
      end
      @(negedge clock);
      n_checks++;
      if ({p1_ack, p2_ack, ram_write_enabled} !== 3'b011 || ram_write_address !== 19'h00200) begin
         n_fail++; $display("FAIL tie_p2_second: ack1/ack2/we=%b addr=%h expected 011 addr 00200",
                            {p1_ack, p2_ack, ram_write_enabled}, ram_write_address);
      end
      p2_req = 0;
      @(negedge clock);
      n_checks++;
      if (mem[19'h00100] !== 1'b1 || mem[19'h00200] !== 1'b1) begin
         n_fail++; $display("FAIL tie_ram: mem100=%b mem200=%b expected 1 1", mem[19'h00100], mem[19'h00200]);
      end
   endtask

   task automatic test_round_robin();
      p1_req = 1; p1_we = 1; p1_addr = 19'd5; p1_wdata = 0;
      @(negedge clock);
      n_checks++;
      if (p1_ack !== 1'b1) begin
         n_fail++; $display("FAIL rr_lone_p1: p1_ack=%b expected 1", p1_ack);
      end
      p1_req = 0;
      @(negedge clock);
      p1_req = 1; p1_addr = 19'd6;
      p2_req = 1; p2_we = 1; p2_addr = 19'd7; p2_wdata = 0;
      @(negedge clock);
      n_checks++;
      if ({p1_ack, p2_ack} !== 2'b01 || ram_write_address !== 19'd7) begin
         n_fail++; $display("FAIL rr_tie_p2: ack1/ack2=%b addr=%0d expected 01 addr 7", {p1_ack, p2_ack}, ram_write_address);
      end
      p2_req = 0;
      repeat (2) @(negedge clock);
      n_checks++;
      if ({p1_ack, p2_ack} !== 2'b10 || ram_write_address !== 19'd6) begin
         n_fail++; $display("FAIL rr_then_p1: ack1/ack2=%b addr=%0d expected 10 addr 6", {p1_ack, p2_ack}, ram_write_address);
      end
      p1_req = 0;
      @(negedge clock);
   endtask

   task automatic test_read();
      logic we_seen;
      preload(19'd6410, 1'b1);
      preload(19'd6411, 1'b0);
      p1_req = 1; p1_we = 0; p1_addr = 19'd6410;
      @(negedge clock);
      we_seen = ram_write_enabled;
      n_checks++;
      if (ram_write_address !== 19'd6410 || p1_ack !== 1'b0) begin
         n_fail++; $display("FAIL read_addr_phase: addr=%0d ack=%b expected 6410 0", ram_write_address, p1_ack);
      end
      @(negedge clock);
      we_seen |= ram_write_enabled;
      n_checks++;
      if (p1_ack !== 1'b0) begin
         n_fail++; $display("FAIL read_data_phase: p1_ack=%b expected 0", p1_ack);
      end
      @(negedge clock);
      we_seen |= ram_write_enabled;
      n_checks++;
      if (p1_ack !== 1'b1 || p1_rdata !== 1'b1 || p2_ack !== 1'b0) begin
         n_fail++; $display("FAIL read_ack: p1_ack=%b p1_rdata=%b p2_ack=%b expected 1 1 0", p1_ack, p1_rdata, p2_ack);
      end
      p1_req = 0;
      @(negedge clock);
      n_checks++;
      if (we_seen !== 1'b0) begin
         n_fail++; $display("FAIL read_no_write: we seen=%b expected 0", we_seen);
      end
      n_checks++;
      if (p1_ack !== 1'b0 || p1_rdata !== 1'b1) begin
         n_fail++; $display("FAIL read_hold: p1_ack=%b p1_rdata=%b expected 0 1", p1_ack, p1_rdata);
      end
      p1_req = 1; p1_addr = 19'd6411;
      repeat (3) @(negedge clock);
      n_checks++;
      if (p1_ack !== 1'b1 || p1_rdata !== 1'b0) begin
         n_fail++; $display("FAIL read_zero: p1_ack=%b p1_rdata=%b expected 1 0", p1_ack, p1_rdata);
      end
      p1_req = 0;
      @(negedge clock);
      p2_req = 1; p2_we = 0; p2_addr = 19'd6410;
      repeat (3) @(negedge clock);
      n_checks++;
      if (p2_ack !== 1'b1 || p2_rdata !== 1'b1 || p1_ack !== 1'b0) begin
         n_fail++; $display("FAIL read_p2: p2_ack=%b p2_rdata=%b p1_ack=%b expected 1 1 0", p2_ack, p2_rdata, p1_ack);
      end
      p2_req = 0;
      @(negedge clock);
   endtask

   task automatic test_clear();
      int cycles;
      int bad;
      clear_start = 1;
      p2_req = 1; p2_we = 1; p2_addr = 19'h10; p2_wdata = 1;
      @(negedge clock);
      clear_start = 0;
      cycles = 0; bad = 0;
      while (clear_busy === 1'b1 && cycles < FB + 10) begin
         if (ram_write_enabled !== 1'b1 || ram_write_data !== 1'b0 ||
             ram_write_address !== 19'(cycles) || p2_ack !== 1'b0) bad++;
         clear_start = (cycles == 100);
         cycles++;
         @(negedge clock);
      end
      clear_start = 0;
      n_checks++;
      if (cycles !== FB) begin
         n_fail++; $display("FAIL clear_length: busy cycles=%0d expected %0d", cycles, FB);
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL clear_sweep: bad cycles=%0d expected 0", bad);
      end
      n_checks++;
      if ({ram_write_enabled, clear_busy, p2_ack} !== 3'b000) begin
         n_fail++; $display("FAIL clear_exit: we/busy/ack2=%b expected 000", {ram_write_enabled, clear_busy, p2_ack});
      end
      @(negedge clock);
      n_checks++;
      if (p2_ack !== 1'b1 || ram_write_enabled !== 1'b1 || ram_write_address !== 19'h10) begin
         n_fail++; $display("FAIL clear_then_p2: ack=%b we=%b addr=%h expected 1 1 10", p2_ack, ram_write_enabled, ram_write_address);
      end
      p2_req = 0;
      @(negedge clock);
      n_checks++;
      if (mem[19'h00100] !== 1'b0 || mem[19'd6410] !== 1'b0) begin
         n_fail++; $display("FAIL clear_ram: mem100=%b mem6410=%b expected 0 0", mem[19'h00100], mem[19'd6410]);
      end
   endtask

   task automatic test_pending_clear();
      int cycles;
      int bad;
      p2_req = 1; p2_we = 0; p2_addr = 19'h10;
      @(negedge clock);
      p1_req = 1; p1_we = 1; p1_addr = 19'h20; p1_wdata = 1;
      @(negedge clock);
      clear_start = 1;
      @(negedge clock);
      clear_start = 0;
      n_checks++;
      if (p2_ack !== 1'b1 || p2_rdata !== 1'b1 || clear_busy !== 1'b0 || p1_ack !== 1'b0) begin
         n_fail++; $display("FAIL pend_p2_ack: ack2=%b rdata2=%b busy=%b ack1=%b expected 1 1 0 0",
                            p2_ack, p2_rdata, clear_busy, p1_ack);
      end
      p2_req = 0;
      @(negedge clock);
      n_checks++;
      if ({p1_ack, p2_ack, clear_busy} !== 3'b000) begin
         n_fail++; $display("FAIL pend_idle: ack1/ack2/busy=%b expected 000", {p1_ack, p2_ack, clear_busy});
      end
      @(negedge clock);
      n_checks++;
      if (clear_busy !== 1'b1 || ram_write_address !== 19'd0 || p1_ack !== 1'b0) begin
         n_fail++; $display("FAIL pend_clear_start: busy=%b addr=%0d ack1=%b expected 1 0 0", clear_busy, ram_write_address, p1_ack);
      end
      cycles = 0; bad = 0;
      while (clear_busy === 1'b1 && cycles < FB + 10) begin
         if (p1_ack !== 1'b0) bad++;
         cycles++;
         @(negedge clock);
      end
      n_checks++;
      if (bad !== 0 || cycles !== FB) begin
         n_fail++; $display("FAIL pend_sweep: ack during clear=%0d cycles=%0d expected 0 %0d", bad, cycles, FB);
      end
      @(negedge clock);
      n_checks++;
      if (p1_ack !== 1'b1 || ram_write_address !== 19'h20 || ram_write_enabled !== 1'b1) begin
         n_fail++; $display("FAIL pend_p1_after: ack1=%b addr=%h we=%b expected 1 20 1", p1_ack, ram_write_address, ram_write_enabled);
      end
      p1_req = 0;
      @(negedge clock);
   endtask

   task automatic test_out_of_range();
      p1_req = 1; p1_we = 1; p1_wdata = 1; p1_addr = 19'(FB - 1);
      @(negedge clock);
      n_checks++;
      if (p1_ack !== 1'b1 || ram_write_enabled !== 1'b1) begin
         n_fail++; $display("FAIL oor_last_in: ack=%b we=%b expected 1 1", p1_ack, ram_write_enabled);
      end
      p1_req = 0;
      @(negedge clock);
      p1_req = 1; p1_addr = 19'(FB);
      @(negedge clock);
      n_checks++;
      if (p1_ack !== 1'b1 || ram_write_enabled !== 1'b0) begin
         n_fail++; $display("FAIL oor_first_out: ack=%b we=%b expected 1 0", p1_ack, ram_write_enabled);
      end
      p1_req = 0;
      @(negedge clock);
      p1_req = 1; p1_addr = 19'd307200;
      @(negedge clock);
      n_checks++;
      if (p1_ack !== 1'b1 || ram_write_enabled !== 1'b0 || ram_write_address !== 19'd307200) begin
         n_fail++; $display("FAIL oor_write: ack=%b we=%b addr=%0d expected 1 0 307200", p1_ack, ram_write_enabled, ram_write_address);
      end
      p1_req = 0;
      @(negedge clock);
      p2_req = 1; p2_we = 0; p2_addr = 19'h30;
      repeat (3) @(negedge clock);
      n_checks++;
      if (p2_ack !== 1'b1 || p2_rdata !== 1'b0) begin
         n_fail++; $display("FAIL oor_inrange_read: ack=%b rdata=%b expected 1 0", p2_ack, p2_rdata);
      end
      p2_req = 0;
      preload(19'd400000, 1'b0);
      p2_req = 1; p2_addr = 19'd400000;
      repeat (3) @(negedge clock);
      n_checks++;
      if (p2_ack !== 1'b1 || p2_rdata !== 1'b1) begin
         n_fail++; $display("FAIL oor_read: ack=%b rdata=%b expected 1 1", p2_ack, p2_rdata);
      end
      p2_req = 0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_read();
      int bad;
      p1_req = 1; p1_we = 0; p1_addr = 19'd6410;
      repeat (2) @(negedge clock);
      reset = 1; p1_req = 0;
      #1;
      n_checks++;
      if (outs !== 26'd0) begin
         n_fail++; $display("FAIL rst_read_outputs: outputs=%h expected 0", outs);
      end
      @(negedge clock);
      reset = 0;
      bad = 0;
      repeat (5) begin
         @(negedge clock);
         if (p1_ack !== 1'b0 || p2_ack !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL rst_read_no_ack: acks after reset=%0d expected 0", bad);
      end
   endtask

   task automatic test_reset_mid_clear();
      int cycles;
      int bad;
      clear_start = 1;
      @(negedge clock);
      clear_start = 0;
      cycles = 0;
      while (ram_write_address !== 19'd1000 && cycles < 2000) begin
         @(negedge clock);
         cycles++;
      end
      n_checks++;
      if (ram_write_address !== 19'd1000 || clear_busy !== 1'b1) begin
         n_fail++; $display("FAIL rstclr_reach: addr=%0d busy=%b expected 1000 1", ram_write_address, clear_busy);
      end
      reset = 1;
      #1;
      n_checks++;
      if (outs !== 26'd0) begin
         n_fail++; $display("FAIL rstclr_outputs: outputs=%h expected 0", outs);
      end
      @(negedge clock);
      reset = 0;
      bad = 0;
      repeat (20) begin
         @(negedge clock);
         if (ram_write_enabled !== 1'b0 || clear_busy !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL rstclr_quiet: active cycles after release=%0d expected 0", bad);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_tie();
      test_round_robin();
      test_read();
      test_clear();
      test_pending_clear();
      test_out_of_range();
      test_reset_mid_read();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
